bincnt_gen7: RTL and testbench
==============================

# bincnt_gen7

Weight-k word generator: the inverse of the team's 7-input ones counter. Given a population count `k`, it emits, one word per accepted beat, every N-bit vector containing exactly `k` ones, in ascending numeric order. It feeds exhaustive stimulus to the counter datapath and to any block that consumes weight-classified vectors. Output uses a valid/ready stream.

## Interface
- `N`, default 7: output word width. Legal range is 2..16.
- `CW`, localparam = $clog2(N+1): width of the count input.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low; one clock, with asynchronous active-low reset.
- `start_valid`  in  1  a request is present.
- `start_ready`  out  1  high only in IDLE.
- `k`  in  CW  requested weight; sampled on the start handshake.
- `abort`  in  1  synchronous cancel of a running sequence.
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  the consumer accepts.
- `out_word`  out  N  current vector.
- `out_idx`  out  N  zero-based index of the current word.
- `out_last`  out  1  current word is the final word, ((1<<k)-1)<<(N-k).
- `busy`  out  1  state is not IDLE.
- `err`  out  1  one-cycle pulse when a request with k>N is rejected.
- `chk_err`  out  1  sticky self-check failure (see Configuration).

## Operation
- States are IDLE and EMIT.
- **IDLE:** `start_ready`=1. On `start_valid`&`start_ready`:
  - If k≤N: load `out_word`=(1<<k)-1 and `out_idx`=0, then go to EMIT.
  - If k>N: pulse `err` and stay in IDLE. No word is emitted.
- **EMIT:** `out_valid`=1.
  - On the `out_valid`&`out_ready` handshake with `out_last`=1: go to IDLE.
  - On a handshake otherwise: load the Gosper successor and increment `out_idx`.
- Successor of x:
  - c = x & -x (lowest set bit); r = x + c.
  - next = r | (((r ^ x) >> 2) >> ctz(c)).
  - Shifting by ctz replaces division. ctz comes from a priority encoder. All arithmetic is N bits wide, and the carry out of r is discarded.
- `out_last` is a registered compare of the next word against the top-k pattern. It is never derived from a carry.
- k=0 emits the single word 0, with `out_last`=1. k=N emits the single word all-ones, with `out_last`=1.
- The sequence length is C(N,k). `out_idx` never wraps because C(N,k) < 2^N.
- **`abort`:**
  - In EMIT, the next state is IDLE and `out_valid` drops.
  - If a handshake occurs in the same cycle, that word counts as consumed and no successor is loaded.
  - In IDLE, `abort` is ignored.
  - If `abort` and a start handshake occur together in IDLE, the start proceeds.
- **`rst_n` low, at any time including mid-sequence:**
  - All outputs and state clear immediately to their reset values.
  - Reset values: `out_valid`=0, `out_word`=0, `out_idx`=0, `out_last`=0, `busy`=0, `err`=0, `chk_err`=0, state IDLE.
  - `start_ready` is 1 in IDLE after reset.

## Timing
- Start handshake at edge t: the first word has `out_valid`=1 from t+1.
- Throughput is one word per cycle while `out_ready`=1.
- While stalled, `out_word`, `out_idx` and `out_last` hold stable.
- Last handshake at edge t: `out_valid`=0 and `start_ready`=1 from t+1. There is a one-cycle gap before a new first word can appear (t+2 at the earliest).
- `err` is high for exactly the cycle after the rejected handshake.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- Macro `BINCNT_GEN_CHECK_EN`.
- **Defined:** a sorter-based ones counter checks every word accepted at a handshake against the registered `k`. A mismatch sets `chk_err` one cycle later. `chk_err` stays set until `rst_n`.
- **Undefined:** the checker is absent and `chk_err` is tied to 0. The port list is identical in both builds.

## Test plan
- N=7, k=0, `out_ready`=1: one word 0000000 with idx 0 and `out_last`=1. `start_ready` returns high 2 cycles after the start.
- N=7, k=3, `out_ready`=1:
  - 35 consecutive words: 0000111, 0001011, 0001101, …, 1110000.
  - The last word is at idx 34 with `out_last`=1.
  - No gaps, all weights equal 3, strictly ascending.
- N=7, k=2, random `out_ready`: 21 words, identical to the unstalled sequence. Words hold during stalls, and no duplicates or drops occur at the handshakes.
- N=7, k=4: assert `abort` during the handshake of idx 5.
  - `out_valid`=0 the next cycle.
  - A new start with k=1 yields 0000001, 0000010, …, 1000000 (7 words).
- N=6, k=7: `err` pulses for 1 cycle, `out_valid` stays 0, and `busy` stays 0. A subsequent start with k=6 yields 111111 with `out_last`=1.
- N=7, k=5: drop `rst_n` at idx 10.
  - All outputs reach their reset values asynchronously.
  - After release, a start with k=5 restarts at 0011111 with idx 0.
  - With `BINCNT_GEN_CHECK_EN` defined, `chk_err` stays 0 throughout.

Source files
------------

// File: rtl/bincnt_gen7_if.sv
// bincnt_gen7_if
// Bundles the request side, the output stream and the status flags of the
// weight-k word generator into one connection.
//   Parameters : N  - output word width (2..16); CW = $clog2(N+1) is the width of k.
//   Request    : start_valid, start_ready, k, abort
//   Stream     : out_valid, out_ready, out_word, out_idx, out_last
//   Status     : busy, err, chk_err
// Modports:
//   master - the generator. It drives start_ready, the stream payload and the status flags.
//   slave  - the requester/consumer. It drives start_valid, k, abort and out_ready.
interface bincnt_gen7_if #(
    parameter int N = 7
);
    localparam int CW = $clog2(N + 1);

    logic          start_valid;
    logic          start_ready;
    logic [CW-1:0] k;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_word;
    logic [N-1:0]  out_idx;
    logic          out_last;
    logic          busy;
    logic          err;
    logic          chk_err;

    modport master (
        input  start_valid, k, abort, out_ready,
        output start_ready, out_valid, out_word, out_idx, out_last, busy, err, chk_err
    );

    modport slave (
        output start_valid, k, abort, out_ready,
        input  start_ready, out_valid, out_word, out_idx, out_last, busy, err, chk_err
    );
endinterface

// File: rtl/bincnt_gen7.sv
// bincnt_gen7
// Weight-k word generator. After a start request carrying k, it streams every
// N-bit vector that has exactly k ones, in ascending numeric order. It emits one
// word per accepted beat, using Gosper's successor step.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - bincnt_gen7_if.master (request, output stream, status flags)
// Optional feature macro: BINCNT_GEN_CHECK_EN
//   When defined, a sorter-based ones counter checks the weight of every
//   accepted word against the latched k. A mismatch sets the sticky chk_err.
//   When undefined, chk_err is tied to 0.
module bincnt_gen7 #(
    parameter int N = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    bincnt_gen7_if.master bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  word_q,  word_d;
    logic [N-1:0]  idx_q,   idx_d;
    logic          last_q,  last_d;
    logic          err_q,   err_d;
    logic [CW-1:0] k_q,     k_d;

    // Bit pattern with the k lowest bits set. A shift by N or more leaves
    // zero, so k = N gives all ones.
    function automatic logic [N-1:0] low_ones(input logic [CW-1:0] kk);
        return ~({N{1'b1}} << kk);
    endfunction

    // Final word of a weight-kk sequence: kk ones packed at the top.
    function automatic logic [N-1:0] top_ones(input logic [CW-1:0] kk);
        return low_ones(kk) << (CW'(N) - kk);
    endfunction

    // Gosper successor of word_q:
    //   c    = x & -x
    //   r    = x + c
    //   next = r | (((r ^ x) >> 2) >> ctz(c))
    // The carry out of r is dropped. That only happens on the final word,
    // whose successor is never loaded.
    logic [N-1:0]  low_bit;
    logic [N-1:0]  ripple;
    logic [N-1:0]  succ;
    logic [CW-1:0] ctz;

    always_comb begin
        low_bit = word_q & (~word_q + N'(1));
        ripple  = word_q + low_bit;
        ctz     = '0;
        // Priority encoder: the scan runs downward, so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (low_bit[i]) ctz = CW'(i);
        end
        succ = ripple | (((ripple ^ word_q) >> 2) >> ctz);
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        last_d  = last_q;
        k_d     = k_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // abort has no effect here, so a start that coincides with it still proceeds.
                if (bus.start_valid) begin
                    if (int'(bus.k) > N) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = bus.k;
                        word_d  = low_ones(bus.k);
                        idx_d   = '0;
                        // A single-word sequence (k = 0 or k = N) is already at its top pattern.
                        last_d  = (low_ones(bus.k) == top_ones(bus.k));
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.abort) begin
                    // A handshake in this same cycle still consumes the word.
                    // No successor is loaded.
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        word_d = succ;
                        idx_d  = idx_q + N'(1);
                        // Compare against the top pattern instead of watching for a carry.
                        last_d = (succ == top_ones(k_q));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
            k_q     <= k_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.out_valid   = (state_q == EMIT);
    assign bus.busy        = (state_q == EMIT);
    assign bus.out_word    = word_q;
    assign bus.out_idx     = idx_q;
    assign bus.out_last    = last_q;
    assign bus.err         = err_q;

`ifdef BINCNT_GEN_CHECK_EN
    // Odd-even transposition sorter over single bits. Each compare-exchange
    // moves a one toward bit 0, so after N stages the word is a thermometer
    // code. The position of its top one is the population count.
    logic [N-1:0]  sorted;
    logic [CW-1:0] pop;
    logic          chk_err_q, chk_err_d;

    always_comb begin
        sorted = word_q;
        for (int s = 0; s < N; s++) begin
            for (int i = s % 2; i < N - 1; i += 2) begin
                sorted[i +: 2] = {sorted[i] & sorted[i+1], sorted[i] | sorted[i+1]};
            end
        end
        pop = '0;
        for (int i = 0; i < N; i++) begin
            if (sorted[i]) pop = CW'(i + 1);
        end
        chk_err_d = chk_err_q |
                    ((state_q == EMIT) && bus.out_ready && (pop != k_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chk_err_q <= 1'b0;
        else        chk_err_q <= chk_err_d;
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_bincnt_gen7.sv
module tb_bincnt_gen7;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_q[$];

    bincnt_gen7_if #(.N(7)) if7 ();
    bincnt_gen7_if #(.N(6)) if6 ();

    bincnt_gen7 #(.N(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(if7));
    bincnt_gen7 #(.N(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: scan every N-bit value upward and keep those of weight kk.
    task automatic build_exp(input int n, input int kk);
        exp_q.delete();
        for (int x = 0; x < (1 << n); x++) begin
            if ($countones(x) == kk) exp_q.push_back(x);
        end
    endtask

    task automatic check_reset7();
        check("rst_valid", if7.out_valid, 0);
        check("rst_word",  if7.out_word,  0);
        check("rst_idx",   if7.out_idx,   0);
        check("rst_last",  if7.out_last,  0);
        check("rst_busy",  if7.busy,      0);
        check("rst_err",   if7.err,       0);
        check("rst_chk",   if7.chk_err,   0);
        check("rst_ready", if7.start_ready, 1);
    endtask

    // Runs one sequence on the N=7 instance.
    // abort_at : index of the handshake at which abort is raised (-1 means none).
    // rst_at   : index at which rst_n is pulled low (-1 means none).
    task automatic run_seq(input int kk, input int ready_pct, input int abort_at,
                           input int rst_at, input bit abort_on_start);
        int pos;
        int cyc;
        bit done;
        bit aborted;
        build_exp(7, kk);
        @(negedge clk);
        check("start_ready", if7.start_ready, 1);
        if7.start_valid = 1'b1;
        if7.k           = 3'(kk);
        if7.abort       = abort_on_start;
        if7.out_ready   = 1'b0;
        @(negedge clk);
        if7.start_valid = 1'b0;
        if7.abort       = 1'b0;
        check("first_valid", if7.out_valid, 1);
        pos = 0; cyc = 0; done = 0; aborted = 0;
        while (!done) begin
            if (cyc >= 1000) begin
                check("timeout", 1, 0);
                break;
            end
            if7.out_ready = ($urandom_range(99) < ready_pct);
            check("valid", if7.out_valid, 1);
            check("busy",  if7.busy, 1);
            check("word",  if7.out_word, exp_q[pos]);
            check("idx",   if7.out_idx, pos);
            check("last",  if7.out_last, (pos == exp_q.size() - 1));
            if (pos == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset7();
                @(negedge clk);
                rst_n = 1'b1;
                $display("txn k=%0d reset at idx %0d", kk, pos);
                return;
            end
            if (if7.out_ready) begin
                if (pos == abort_at) begin
                    if7.abort = 1'b1;
                    aborted   = 1'b1;
                end
                pos++;
            end
            @(negedge clk);
            if7.abort = 1'b0;
            cyc++;
            if (aborted) begin
                check("abort_drop",  if7.out_valid, 0);
                check("abort_ready", if7.start_ready, 1);
                done = 1;
            end else if (pos == exp_q.size()) begin
                check("end_valid", if7.out_valid, 0);
                check("end_ready", if7.start_ready, 1);
                done = 1;
            end
        end
        $display("txn k=%0d words=%0d of %0d aborted=%0d", kk, pos, exp_q.size(), aborted);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if7.start_valid = 1'b0; if7.k = '0; if7.abort = 1'b0; if7.out_ready = 1'b0;
        if6.start_valid = 1'b0; if6.k = '0; if6.abort = 1'b0; if6.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset7();
        rst_n = 1'b1;

        run_seq(0, 100, -1, -1, 1'b0);
        run_seq(3, 100, -1, -1, 1'b0);
        run_seq(2, 50,  -1, -1, 1'b0);
        run_seq(4, 100,  5, -1, 1'b0);
        run_seq(1, 100, -1, -1, 1'b0);
        run_seq(7, 100, -1, -1, 1'b0);

        // N=6: a request for k=7 is rejected.
        @(negedge clk);
        if6.start_valid = 1'b1;
        if6.k           = 3'd7;
        @(negedge clk);
        if6.start_valid = 1'b0;
        check("err_pulse", if6.err, 1);
        check("err_valid", if6.out_valid, 0);
        check("err_busy",  if6.busy, 0);
        @(negedge clk);
        check("err_clear", if6.err, 0);
        check("err_valid2", if6.out_valid, 0);
        check("err_ready", if6.start_ready, 1);
        $display("txn n6 k=7 rejected");
        if6.start_valid = 1'b1;
        if6.k           = 3'd6;
        if6.out_ready   = 1'b1;
        @(negedge clk);
        if6.start_valid = 1'b0;
        check("n6_valid", if6.out_valid, 1);
        check("n6_word",  if6.out_word, 32'h3f);
        check("n6_last",  if6.out_last, 1);
        @(negedge clk);
        check("n6_end", if6.out_valid, 0);
        $display("txn n6 k=6 words=1");

        run_seq(5, 100, -1, 10, 1'b0);
        run_seq(5, 100, -1, -1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_seq($urandom_range(7), $urandom_range(100, 30), -1, -1, 1'($urandom_range(1)));
        end

        check("chk_err7", if7.chk_err, 0);
        check("chk_err6", if6.chk_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
